resource_arbiter: RTL

RESOURCE_ARBITER -- requirements
Module: resource_arbiter

---
 rtl/resource_arbiter_pkg.sv | 28 ++
 rtl/rr_picker.sv | 28 ++
 rtl/resource_arbiter.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/resource_arbiter_pkg.sv
// Shared widths, FSM encodings and payload types for the resource arbiter.
package resource_arbiter_pkg;

    localparam int unsigned ADDRESS_WIDTH   = 12;
    localparam int unsigned DATA_WIDTH      = 16;
    localparam int unsigned ID_WIDTH        = 4;
    localparam int unsigned DEFAULT_TIMEOUT = 64;

    localparam int unsigned STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE        = 3'd0;
    localparam logic [STATE_W-1:0] ST_ISSUE       = 3'd1;
    localparam logic [STATE_W-1:0] ST_WAIT_ACCEPT = 3'd2;
    localparam logic [STATE_W-1:0] ST_WAIT_RSP    = 3'd3;
    localparam logic [STATE_W-1:0] ST_DRAIN       = 3'd4;

    // Request payload latched at grant and presented to the resource.
    typedef struct packed {
        logic [ADDRESS_WIDTH-1:0] addr;
        logic [ID_WIDTH-1:0]      id;
    } req_payload_t;

    // Pointer width that stays legal for a single requester.
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first requester at or after the pointer wins.
module rr_picker #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant_c
);

    logic             w_found;
    logic [PTR_W-1:0] w_idx;

    // Scan requesters in rotated order starting at the pointer.
    always_comb begin
        o_grant_c = '0;
        w_found   = 1'b0;
        w_idx     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_idx = PTR_W'((int'(i_ptr) + i) % NUM_REQ);
            if (!w_found && i_req[w_idx]) begin
                o_grant_c[w_idx] = 1'b1;
                w_found          = 1'b1;
            end
        end
    end

endmodule

// File: rtl/resource_arbiter.sv
// Round-robin arbiter giving NUM_REQ requesters single-outstanding access to one resource.
module resource_arbiter
    import resource_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_address,
    input  logic [NUM_REQ*ID_WIDTH-1:0]   req_id,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic [ID_WIDTH-1:0]           rsp_id,
    output logic                          rsp_error,
    output logic [ADDRESS_WIDTH-1:0]      res_address,
    output logic [ID_WIDTH-1:0]           res_id,
    output logic                          res_in_valid,
    input  logic [DATA_WIDTH-1:0]         res_data,
    input  logic [ID_WIDTH-1:0]           res_out_id,
    input  logic                          res_out_valid,
    input  logic                          res_ready
);

    localparam int unsigned PTR_W = ptr_width(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [STATE_W-1:0]    r_state;
    logic [PTR_W-1:0]      r_ptr;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_rst_done;
    req_payload_t          r_req;
    logic [PTR_W-1:0]      r_idx;
    logic [NUM_REQ-1:0]    r_req_ready;
    logic [NUM_REQ-1:0]    r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_data;
    logic [ID_WIDTH-1:0]   r_rsp_id;
    logic                  r_rsp_error;
    logic                  r_res_in_valid;

    logic [STATE_W-1:0]    w_state_nxt;
    logic [PTR_W-1:0]      w_ptr_nxt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    req_payload_t          w_req_nxt;
    logic [PTR_W-1:0]      w_idx_nxt;
    logic [NUM_REQ-1:0]    w_req_ready_nxt;
    logic [NUM_REQ-1:0]    w_rsp_valid_nxt;
    logic [DATA_WIDTH-1:0] w_rsp_data_nxt;
    logic [ID_WIDTH-1:0]   w_rsp_id_nxt;
    logic                  w_rsp_error_nxt;
    logic                  w_res_in_valid_nxt;

    logic [NUM_REQ-1:0]    w_grant;
    logic [PTR_W-1:0]      w_grant_idx;
    req_payload_t          w_sel;
    logic                  w_timeout;
    logic                  w_waiting;
    logic                  w_can_grant;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_picker (
        .i_req     (req_valid),
        .i_ptr     (r_ptr),
        .o_grant_c (w_grant)
    );

    // Encode the one-hot grant and select the winning requester's payload.
    always_comb begin
        w_grant_idx = '0;
        w_sel       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_grant_idx = PTR_W'(i);
                w_sel.addr  = req_address[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                w_sel.id    = req_id[i*ID_WIDTH +: ID_WIDTH];
            end
        end
    end

    assign w_timeout   = (r_cnt == CNT_W'(TIMEOUT_CYCLES));
    assign w_waiting   = (r_state == ST_WAIT_ACCEPT) || (r_state == ST_WAIT_RSP) ||
                         (r_state == ST_DRAIN);
    // Hold off one edge after reset and while the resource still shows an old result.
    assign w_can_grant = r_rst_done && (|req_valid) && res_ready && !res_out_valid;

    // Next-state and next-output computation for the transaction FSM.
    always_comb begin
        w_state_nxt        = r_state;
        w_ptr_nxt          = r_ptr;
        w_req_nxt          = r_req;
        w_idx_nxt          = r_idx;
        w_req_ready_nxt    = '0;
        w_rsp_valid_nxt    = '0;
        w_rsp_data_nxt     = r_rsp_data;
        w_rsp_id_nxt       = r_rsp_id;
        w_rsp_error_nxt    = 1'b0;
        w_res_in_valid_nxt = 1'b0;
        w_cnt_nxt          = '0;

        case (r_state)
            ST_IDLE: begin
                if (w_can_grant) begin
                    w_state_nxt        = ST_ISSUE;
                    w_req_nxt          = w_sel;
                    w_idx_nxt          = w_grant_idx;
                    w_req_ready_nxt    = w_grant;
                    w_res_in_valid_nxt = 1'b1;
                    w_ptr_nxt          = (w_grant_idx == PTR_W'(NUM_REQ - 1)) ?
                                         '0 : w_grant_idx + PTR_W'(1);
                end
            end
            ST_ISSUE: begin
                w_state_nxt = ST_WAIT_ACCEPT;
            end
            ST_WAIT_ACCEPT: begin
                if (!res_ready) begin
                    w_state_nxt = ST_WAIT_RSP;
                end else if (w_timeout) begin
                    w_state_nxt     = ST_DRAIN;
                    w_rsp_error_nxt = 1'b1;
                end
            end
            ST_WAIT_RSP: begin
                if (res_out_valid) begin
                    w_state_nxt = ST_DRAIN;
                    if (res_out_id == r_req.id) begin
                        w_rsp_valid_nxt[r_idx] = 1'b1;
                        w_rsp_data_nxt         = res_data;
                        w_rsp_id_nxt           = res_out_id;
                    end else begin
                        w_rsp_error_nxt = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_state_nxt     = ST_DRAIN;
                    w_rsp_error_nxt = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (!res_out_valid) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_timeout) begin
                    w_state_nxt     = ST_IDLE;
                    w_rsp_error_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Wait counter restarts on every state change and only runs in waiting states.
        if (w_waiting && (w_state_nxt == r_state)) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end
    end

    // State and registered outputs; reset clears everything immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= ST_IDLE;
            r_ptr          <= '0;
            r_cnt          <= '0;
            r_rst_done     <= 1'b0;
            r_req          <= '0;
            r_idx          <= '0;
            r_req_ready    <= '0;
            r_rsp_valid    <= '0;
            r_rsp_data     <= '0;
            r_rsp_id       <= '0;
            r_rsp_error    <= 1'b0;
            r_res_in_valid <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_ptr          <= w_ptr_nxt;
            r_cnt          <= w_cnt_nxt;
            r_rst_done     <= 1'b1;
            r_req          <= w_req_nxt;
            r_idx          <= w_idx_nxt;
            r_req_ready    <= w_req_ready_nxt;
            r_rsp_valid    <= w_rsp_valid_nxt;
            r_rsp_data     <= w_rsp_data_nxt;
            r_rsp_id       <= w_rsp_id_nxt;
            r_rsp_error    <= w_rsp_error_nxt;
            r_res_in_valid <= w_res_in_valid_nxt;
        end
    end

    assign req_ready    = r_req_ready;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_data     = r_rsp_data;
    assign rsp_id       = r_rsp_id;
    assign rsp_error    = r_rsp_error;
    assign res_address  = r_req.addr;
    assign res_id       = r_req.id;
    assign res_in_valid = r_res_in_valid;

endmodule
